// File: rtl/random_numb.sv
// ============================================================================
//  Module      : random_numb
//  Description : Free-running 4-bit maximal-length LFSR sampled into a held
//                output register on each rising edge of the button pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module random_numb #(
    parameter logic [3:0] SEED = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    output logic [3:0] count
);

    // A zero seed would park the LFSR in its lock-up state, so it maps to 1.
    localparam logic [3:0] c_SEED = (SEED == 4'b0000) ? 4'b0001 : SEED;

    logic [3:0] r_lfsr;
    logic [3:0] r_count;
    logic       r_pulse_d;
    logic       w_rise;
    logic [3:0] w_lfsr_next;

    assign w_rise      = pulse & ~r_pulse_d;
    assign w_lfsr_next = (r_lfsr == 4'b0000) ? c_SEED
                                             : {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};

    // pulse_d resets high so a pulse held across reset release is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= c_SEED;
            r_count   <= 4'b0000;
            r_pulse_d <= 1'b1;
        end else begin
            r_lfsr    <= w_lfsr_next;
            r_pulse_d <= pulse;
            if (w_rise) begin
                r_count <= r_lfsr;
            end
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_random_numb.sv
// ============================================================================
//  Module      : tb_random_numb
//  Description : Self-checking bench for random_numb against a sequence-table
//                model indexed by edges elapsed since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_random_numb;

    logic       clk;
    logic       rst;
    logic       pulse;
    logic [3:0] count;

    int total_checks  = 0;
    int passed_checks = 0;

    // Expected LFSR value present before edge k (k = 1, 2, ...) is seq_tab[(k-1) % 15].
    logic [3:0] seq_tab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    int         m_edges     = 0;
    logic [3:0] m_count     = 4'b0000;
    logic       m_prev      = 1'b1;
    logic [15:0] seen_mask;

    random_numb #(.SEED(4'b0001)) dut (
        .clk   (clk),
        .rst   (rst),
        .pulse (pulse),
        .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %b, expected %b at time %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a press samples the table entry for the current edge index.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges = 0;
            m_count = 4'b0000;
            m_prev  = 1'b1;
        end else begin
            if (pulse && !m_prev) begin
                m_count = seq_tab[m_edges % 15];
            end
            m_prev  = pulse;
            m_edges = m_edges + 1;
        end
    end

    always @(negedge clk) begin
        check("model_count", count, m_count);
        check("model_lfsr", dut.r_lfsr, seq_tab[m_edges % 15]);
    end

    // One clock edge with pulse driven to p; returns 2 time units after the edge.
    task automatic tick(input logic p);
        pulse = p;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic p);
        pulse = p;
        rst   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        pulse = 1'b0;

        // Asynchronous reset before any clock edge.
        #3 rst = 1'b1;
        #1;
        check("async_reset_count", count, 4'b0000);
        check("async_reset_lfsr", dut.r_lfsr, 4'b0001);
        @(posedge clk);
        #2 rst = 1'b0;

        // Basic capture at edge 3, held for 4 more edges.
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("capture_edge3", count, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            check("hold_high", count, 4'b0100);
        end

        // Second capture at edge 10.
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        check("capture_edge10", count, 4'b1011);

        // Mid-cycle reset while count is non-zero.
        #1 rst = 1'b1;
        #1;
        check("reset_clears_count", count, 4'b0000);

        // Pulse held high through reset and release: no capture.
        pulse = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        tick(1'b1);
        check("held_through_reset", count, 4'b0000);

        // Wrap-around: every value 1..15 over 15 edges, LFSR back to 0001 after edge 15.
        seen_mask = 16'h0000;
        seen_mask[dut.r_lfsr] = 1'b1;
        for (int e = 2; e <= 15; e++) begin
            tick(1'b0);
            seen_mask[dut.r_lfsr] = 1'b1;
        end
        check("wrap_lfsr", dut.r_lfsr, 4'b0001);
        total_checks++;
        if (seen_mask == 16'hFFFE) begin
            passed_checks++;
        end else begin
            $display("FAIL full_period: got mask %h, expected fffe", seen_mask);
        end
        tick(1'b1);
        check("capture_edge16", count, 4'b0001);
        check("no_zero_after_capture", (count == 4'b0000) ? 4'b0001 : 4'b0000, 4'b0000);

        // Single-cycle pulses at edges 5 and 7.
        do_reset(1'b0);
        for (int e = 1; e <= 4; e++) tick(1'b0);
        tick(1'b1);
        check("single_edge5", count, 4'b0011);
        tick(1'b0);
        tick(1'b1);
        check("single_edge7", count, 4'b1101);
        tick(1'b0);

        // Randomised presses with occasional resets; the compare process checks every cycle.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                tick(($urandom_range(0, 2) == 0) ? ~pulse : pulse);
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

`default_nettype wire
